// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - RV32I branch resolution with a 2-bit counter BHT for fetch prediction
// Optional hit/mispredict statistics counters: define BRANCH_STATS_EN.
module branch_predict_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_pred_taken_o,
    input  logic            ex_valid_i,
    input  logic            ex_branch_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_rs1_i,
    input  logic [XLEN-1:0] ex_rs2_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            ex_pred_taken_i,
    output logic            res_valid_o,
    output logic            res_taken_o,
    output logic            res_mispredict_o,
    output logic            res_illegal_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o
`endif
);

    localparam int IDXW = $clog2(BHT_DEPTH);

    logic [1:0]      cnt_q [BHT_DEPTH];
    logic [1:0]      cnt_d [BHT_DEPTH];
    logic [IDXW-1:0] if_idx;
    logic [IDXW-1:0] ex_idx;
    logic            fire;
    logic            illegal;
    logic            taken;
    logic            legal_fire;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            res_valid_q, res_valid_d;
    logic            res_taken_q, res_taken_d;
    logic            res_mispredict_q, res_mispredict_d;
    logic            res_illegal_q, res_illegal_d;
    logic            unused_pc_bits;

    assign if_idx = if_pc_i[IDXW+1:2];
    assign ex_idx = ex_pc_i[IDXW+1:2];
    assign unused_pc_bits = ^{if_pc_i[XLEN-1:IDXW+2], if_pc_i[1:0],
                              ex_pc_i[XLEN-1:IDXW+2], ex_pc_i[1:0]};

    // Table read sees the registered state, so a same-cycle update is not forwarded.
    assign if_pred_taken_o = cnt_q[if_idx][1];

    assign fire = ex_valid_i & ex_branch_i;
    assign eq   = (ex_rs1_i == ex_rs2_i);
    assign lt_s = ($signed(ex_rs1_i) < $signed(ex_rs2_i));
    assign lt_u = (ex_rs1_i < ex_rs2_i);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (ex_funct3_i)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt_s;
            3'b101:  taken = ~lt_s;
            3'b110:  taken = lt_u;
            3'b111:  taken = ~lt_u;
            default: illegal = 1'b1;
        endcase
    end

    assign legal_fire = fire & ~illegal;

    always_comb begin
        res_valid_d      = fire;
        res_taken_d      = legal_fire & taken;
        res_mispredict_d = legal_fire & (taken ^ ex_pred_taken_i);
        res_illegal_d    = fire & illegal;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (legal_fire) begin
            if (taken && cnt_q[ex_idx] != 2'b11) begin
                cnt_d[ex_idx] = cnt_q[ex_idx] + 2'b01;
            end else if (!taken && cnt_q[ex_idx] != 2'b00) begin
                cnt_d[ex_idx] = cnt_q[ex_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            res_illegal_q    <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_mispredict_q <= res_mispredict_d;
            res_illegal_q    <= res_illegal_d;
        end
    end

    assign res_valid_o      = res_valid_q;
    assign res_taken_o      = res_taken_q;
    assign res_mispredict_o = res_mispredict_q;
    assign res_illegal_o    = res_illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (legal_fire && stat_branches_q != 32'hFFFF_FFFF) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (res_mispredict_d && stat_mispred_q != 32'hFFFF_FFFF) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_branches_q <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches_o = stat_branches_q;
    assign stat_mispred_o  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit against a behavioural model
module tb_branch_predict_unit;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic        if_pred_taken_o;
    logic        ex_valid_i = 1'b0;
    logic        ex_branch_i = 1'b0;
    logic [2:0]  ex_funct3_i = '0;
    logic [31:0] ex_rs1_i = '0;
    logic [31:0] ex_rs2_i = '0;
    logic [31:0] ex_pc_i = '0;
    logic        ex_pred_taken_i = 1'b0;
    logic        res_valid_o;
    logic        res_taken_o;
    logic        res_mispredict_o;
    logic        res_illegal_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_o;
    logic [31:0] stat_mispred_o;
`endif

    branch_predict_unit dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .if_pc_i          (if_pc_i),
        .if_pred_taken_o  (if_pred_taken_o),
        .ex_valid_i       (ex_valid_i),
        .ex_branch_i      (ex_branch_i),
        .ex_funct3_i      (ex_funct3_i),
        .ex_rs1_i         (ex_rs1_i),
        .ex_rs2_i         (ex_rs2_i),
        .ex_pc_i          (ex_pc_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .res_valid_o      (res_valid_o),
        .res_taken_o      (res_taken_o),
        .res_mispredict_o (res_mispredict_o),
        .res_illegal_o    (res_illegal_o)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches_o  (stat_branches_o),
        .stat_mispred_o   (stat_mispred_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          valid;
        bit          taken;
        bit          mis;
        bit          ill;
        logic [31:0] n_br;
        logic [31:0] n_mis;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    int          model_cnt[64];
    logic [31:0] model_br = 0;
    logic [31:0] model_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
        sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
        case (f3)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit model_pred(input logic [31:0] pc);
        return model_cnt[idx_of(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_cnt[i] = 1;
        model_br = 0;
        model_mis = 0;
    endtask

    task automatic step(input bit v, input bit br, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input bit pred,
                        input logic [31:0] ipc);
        exp_t e;
        bit   fire, ill, tk;
        int   ix;
        @(negedge clk_i);
        ex_valid_i      = v;
        ex_branch_i     = br;
        ex_funct3_i     = f3;
        ex_rs1_i        = a;
        ex_rs2_i        = b;
        ex_pc_i         = pc;
        ex_pred_taken_i = pred;
        if_pc_i         = ipc;
        #1;
        chk("if_pred", {31'd0, if_pred_taken_o}, {31'd0, model_pred(ipc)});
        fire = v && br;
        ill  = fire && (f3 == 3'd2 || f3 == 3'd3);
        tk   = fire && !ill && ref_taken(f3, a, b);
        if (fire && !ill) begin
            ix = idx_of(pc);
            model_cnt[ix] = tk ? ((model_cnt[ix] < 3) ? model_cnt[ix] + 1 : 3)
                               : ((model_cnt[ix] > 0) ? model_cnt[ix] - 1 : 0);
            if (model_br != 32'hFFFF_FFFF) model_br++;
            if (tk != pred && model_mis != 32'hFFFF_FFFF) model_mis++;
        end
        e.valid = fire;
        e.taken = tk;
        e.mis   = fire && !ill && (tk != pred);
        e.ill   = ill;
        e.n_br  = model_br;
        e.n_mis = model_mis;
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, ipc);
    endtask

    // Fire is set up, then reset lands before the edge that would have captured it.
    task automatic reset_mid(input logic [31:0] probe_pc);
        exp_t e;
        @(negedge clk_i);
        ex_valid_i      = 1'b1;
        ex_branch_i     = 1'b1;
        ex_funct3_i     = 3'd0;
        ex_rs1_i        = 32'd7;
        ex_rs2_i        = 32'd7;
        ex_pc_i         = probe_pc;
        ex_pred_taken_i = 1'b0;
        if_pc_i         = probe_pc;
        #2;
        rstn_i = 1'b0;
        model_reset();
        e = '{valid: 1'b0, taken: 1'b0, mis: 1'b0, ill: 1'b0, n_br: 32'd0, n_mis: 32'd0};
        sb_q.push_back(e);
        #1;
        chk("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        chk("rst_res_taken", {31'd0, res_taken_o}, 32'd0);
        chk("rst_if_pred", {31'd0, if_pred_taken_o}, {31'd0, model_pred(probe_pc)});
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        rstn_i     = 1'b1;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() == 0) begin
                chk("res_valid_unexpected", {31'd0, res_valid_o}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("res_valid", {31'd0, res_valid_o}, {31'd0, e.valid});
                chk("res_taken", {31'd0, res_taken_o}, {31'd0, e.taken});
                chk("res_mispredict", {31'd0, res_mispredict_o}, {31'd0, e.mis});
                chk("res_illegal", {31'd0, res_illegal_o}, {31'd0, e.ill});
`ifdef BRANCH_STATS_EN
                chk("stat_branches", stat_branches_o, e.n_br);
                chk("stat_mispred", stat_mispred_o, e.n_mis);
`endif
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] a, b, pc, ipc;
        int          r;
        model_reset();
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            if_pc_i = $urandom;
            #1;
            chk("reset_if_pred", {31'd0, if_pred_taken_o}, 32'd0);
        end
        chk("reset_res_valid", {31'd0, res_valid_o}, 32'd0);
        chk("reset_res_mispredict", {31'd0, res_mispredict_o}, 32'd0);
        chk("reset_res_illegal", {31'd0, res_illegal_o}, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        mon_en = 1'b1;

        step(1, 1, 3'd0, 32'd5, 32'd5, 32'h40, 0, 32'h40);
        idle(32'h40);
        step(1, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h80, 0, 32'h80);
        step(1, 1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h84, 0, 32'h84);
        step(1, 1, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'h88, 1, 32'h88);
        step(1, 1, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8C, 1, 32'h8C);

        for (int i = 0; i < 4; i++) step(1, 1, 3'd0, 32'd0, 32'd0, 32'h100, 1, 32'h100);
        for (int i = 0; i < 4; i++) step(1, 1, 3'd1, 32'd0, 32'd0, 32'h102, 0, 32'h100);
        idle(32'h100);

        step(1, 1, 3'd2, 32'd3, 32'd3, 32'h40, 1, 32'h40);
        step(1, 1, 3'd3, 32'd3, 32'd4, 32'h40, 0, 32'h40);
        step(0, 1, 3'd0, 32'd3, 32'd3, 32'h40, 0, 32'h40);
        step(1, 0, 3'd0, 32'd3, 32'd3, 32'h40, 0, 32'h40);
        idle(32'h40);

        step(1, 1, 3'd0, 32'd1, 32'd1, 32'h40, 1, 32'h40);
        reset_mid(32'h40);
        step(1, 1, 3'd0, 32'd1, 32'd1, 32'h40, 0, 32'h40);
        idle(32'h40);

        for (int n = 0; n < 400; n++) begin
            b   = $urandom;
            r   = $urandom_range(0, 3);
            a   = (r == 0) ? b : (r == 1) ? (b ^ 32'h8000_0000) : (r == 2) ? b + 32'd1 : $urandom;
            pc  = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
            ipc = ($urandom_range(0, 1) == 1) ? pc
                                              : (($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom),
                 a, b, pc, 1'($urandom), ipc);
            if (n == 200) reset_mid(ipc);
        end

        idle(32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
